// File: rtl/readout_sequencer_if.sv
// Bundle of event-control, channel and output-stream signals for readout_sequencer.
// The slave modport is the sequencer side; master is the driver/host side.
interface readout_sequencer_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 12,
    parameter int SIZE  = 8,
    parameter int OW    = 16
);
    logic                   start;
    logic [NCH-1:0]         ch_mask;
    logic [SIZE-1:0]        howmany;
    logic [SIZE:0]          fifo_space;
    logic [NCH*WIDTH-1:0]   ch_dout;
    logic [NCH-1:0]         ch_rd_request;
    logic [OW-1:0]          out_data;
    logic                   out_valid;
    logic                   busy;
    logic                   done;
    logic [7:0]             evt_count;
    logic                   err;

    modport slave (
        input  start, ch_mask, howmany, fifo_space, ch_dout,
        output ch_rd_request, out_data, out_valid, busy, done, evt_count, err
    );

    modport master (
        output start, ch_mask, howmany, fifo_space, ch_dout,
        input  ch_rd_request, out_data, out_valid, busy, done, evt_count, err
    );
endinterface

// File: rtl/readout_sequencer.sv
// Event-level readout controller: walks enabled channels in ascending order,
// emits a header per channel, requests its data and forwards howmany samples
// into a single registered output stream.
module readout_sequencer #(
    parameter int NCH      = 4,
    parameter int WIDTH    = 12,
    parameter int SIZE     = 8,
    parameter int READ_LAT = 2,
    parameter int OW       = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    readout_sequencer_if.slave bus
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    // r_lat only has to hold READ_LAT-1
    localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WAIT_SPACE,
        S_HDR,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t            r_state, r_state_next;
    logic [IW-1:0]     r_idx, r_idx_next;
    logic [NCH-1:0]    r_mask, r_mask_next;
    logic [SIZE-1:0]   r_howmany, r_howmany_next;
    logic [LW-1:0]     r_lat, r_lat_next;
    logic [SIZE-1:0]   r_word, r_word_next;
    logic [OW-1:0]     r_out_data, r_out_data_next;
    logic              r_out_valid, r_out_valid_next;
    logic [7:0]        r_evt_count, r_evt_count_next;
    logic              r_err, r_err_next;

    logic [WIDTH-1:0]  w_ch [NCH];
    logic              w_found;
    logic [IW-1:0]     w_scan_idx;
    logic              w_space_ok;
    logic [OW-1:0]     w_hdr;

    // Split the flat DOUT bus into per-channel samples and decode the read requests
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        assign w_ch[gi] = bus.ch_dout[gi*WIDTH +: WIDTH];
        assign bus.ch_rd_request[gi] = (r_state == S_HDR) && (r_idx == IW'(gi));
    end

    // Lowest enabled channel at or above the current index
    always_comb begin
        w_found    = 1'b0;
        w_scan_idx = r_idx;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_mask[i] && (IW'(i) >= r_idx)) begin
                w_found    = 1'b1;
                w_scan_idx = IW'(i);
            end
        end
    end

    // Header + howmany data words must all fit; compared at SIZE+1 bits so 2^SIZE is representable
    assign w_space_ok = (bus.fifo_space >= ({1'b0, r_howmany} + (SIZE+1)'(1)));

    // Header fields left-aligned in the output word, zero-filled below
    always_comb begin
        w_hdr = '0;
        w_hdr[OW-1 -: 16] = {4'hA, 4'(r_idx), r_evt_count};
    end

    // State register and all datapath registers; async reset abandons any event
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_mask      <= '0;
            r_howmany   <= '0;
            r_lat       <= '0;
            r_word      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_evt_count <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= r_state_next;
            r_idx       <= r_idx_next;
            r_mask      <= r_mask_next;
            r_howmany   <= r_howmany_next;
            r_lat       <= r_lat_next;
            r_word      <= r_word_next;
            r_out_data  <= r_out_data_next;
            r_out_valid <= r_out_valid_next;
            r_evt_count <= r_evt_count_next;
            r_err       <= r_err_next;
        end
    end

    // Next-state and next-output logic for the channel walk
    always_comb begin
        r_state_next     = r_state;
        r_idx_next       = r_idx;
        r_mask_next      = r_mask;
        r_howmany_next   = r_howmany;
        r_lat_next       = r_lat;
        r_word_next      = r_word;
        r_out_data_next  = r_out_data;
        r_out_valid_next = 1'b0;
        r_evt_count_next = r_evt_count;
        r_err_next       = r_err;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    r_mask_next    = bus.ch_mask;
                    r_howmany_next = bus.howmany;
                    r_idx_next     = '0;
                    r_err_next     = 1'b0;
                    r_state_next   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!w_found || (r_howmany == '0)) begin
                    r_state_next = S_DONE;
                end else begin
                    r_idx_next   = w_scan_idx;
                    r_state_next = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (w_space_ok) begin
                    r_state_next = S_HDR;
                end
            end
            S_HDR: begin
                // Header lands on the output the cycle after the read request
                r_out_valid_next = 1'b1;
                r_out_data_next  = w_hdr;
                r_lat_next       = LW'(READ_LAT - 1);
                r_word_next      = '0;
                r_state_next     = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (r_lat != '0) begin
                    r_lat_next = r_lat - LW'(1);
                end else begin
                    r_out_valid_next = 1'b1;
                    r_out_data_next  = OW'(w_ch[r_idx]);
                    r_word_next      = r_word + SIZE'(1);
                    if (r_word == (r_howmany - SIZE'(1))) begin
                        if (r_idx == LAST_IDX) begin
                            r_state_next = S_DONE;
                        end else begin
                            r_idx_next   = r_idx + IW'(1);
                            r_state_next = S_SCAN;
                        end
                    end
                end
            end
            S_DONE: begin
                r_evt_count_next = r_evt_count + 8'd1;
                r_state_next     = S_IDLE;
            end
            default: begin
                r_state_next = S_IDLE;
            end
        endcase

        // A start outside IDLE (including the DONE cycle) is dropped and flagged
        if (bus.start && (r_state != S_IDLE)) begin
            r_err_next = 1'b1;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.evt_count = r_evt_count;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: channel ring-buffer model, scoreboard of
// expected stream words, and one task per scenario.
module tb_readout_sequencer;

    localparam int NCH      = 4;
    localparam int WIDTH    = 12;
    localparam int SIZE     = 8;
    localparam int READ_LAT = 2;
    localparam int OW       = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    readout_sequencer_if #(.NCH(NCH), .WIDTH(WIDTH), .SIZE(SIZE), .OW(OW)) bus ();

    readout_sequencer #(
        .NCH(NCH), .WIDTH(WIDTH), .SIZE(SIZE), .READ_LAT(READ_LAT), .OW(OW)
    ) dut (
        .CLK(clk),
        .RESET_N(rst_n),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [7:0] exp_evt = 8'd0;

    logic [OW-1:0] exp_q [$];
    int rq_ch [$];
    int rq_cyc [$];
    int vq_cyc [$];
    int done_cnt = 0;
    int done_cyc = 0;

    // Channel model: after rd_request, word k appears READ_LAT+k cycles later
    int ncnt [NCH];
    logic [WIDTH-1:0] base [NCH];

    always @(posedge clk) cyc <= cyc + 1;

    // Per-channel cycle counter since its last read request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) ncnt[i] <= 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_rd_request[i]) ncnt[i] <= 1;
                else if (ncnt[i] > 0 && ncnt[i] < 1000) ncnt[i] <= ncnt[i] + 1;
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_dout
        assign bus.ch_dout[gi*WIDTH +: WIDTH] =
            (ncnt[gi] >= READ_LAT) ? base[gi] + 12'(ncnt[gi] - READ_LAT) : 12'hEEE;
    end

    // Monitor: logs requests/valid cycles and scores every stream word
    always @(negedge clk) begin
        if (bus.ch_rd_request != '0) begin
            int ch;
            ch = 0;
            for (int i = NCH - 1; i >= 0; i--) if (bus.ch_rd_request[i]) ch = i;
            rq_ch.push_back(ch);
            rq_cyc.push_back(cyc);
            n_checks++;
            if ($countones(bus.ch_rd_request) != 1)
                $display("FAIL rd_request_onehot: got %b required one-hot", bus.ch_rd_request);
            else n_pass++;
        end
        if (bus.out_valid) begin
            vq_cyc.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL stream_extra: got %h required no word (cycle %0d)", bus.out_data, cyc);
            end else begin
                logic [OW-1:0] e;
                e = exp_q.pop_front();
                if (bus.out_data !== e)
                    $display("FAIL stream_word: got %h required %h (cycle %0d)", bus.out_data, e, cyc);
                else begin
                    n_pass++;
                    $display("word %h at cycle %0d", bus.out_data, cyc);
                end
            end
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_logs();
        rq_ch.delete();
        rq_cyc.delete();
        vq_cyc.delete();
    endtask

    // Push the expected stream of one event onto the scoreboard
    task automatic expect_event(input logic [NCH-1:0] m, input logic [SIZE-1:0] h);
        if (h == 0) return;
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) begin
                exp_q.push_back(16'({4'hA, 4'(i), exp_evt}));
                for (int k = 0; k < int'(h); k++)
                    exp_q.push_back(16'(base[i] + 12'(k)));
            end
        end
    endtask

    // Called just after a falling edge; start is high for exactly one cycle
    task automatic pulse_start(input logic [NCH-1:0] m, input logic [SIZE-1:0] h, output int s_cyc);
        bus.ch_mask = m;
        bus.howmany = h;
        bus.start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = done_cnt;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.ch_mask = '0;
        bus.howmany = '0;
        bus.fifo_space = 9'h1FF;
        for (int i = 0; i < NCH; i++) base[i] = 12'(i * 256 + 16);
        rst_n = 1'b0;
        exp_evt = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== '0) $display("FAIL reset_out_data: got %h required 0", bus.out_data); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_busy_done: got %b%b required 00", bus.busy, bus.done); else n_pass++;
        n_checks++; if (bus.evt_count !== 8'd0) $display("FAIL reset_evt_count: got %0d required 0", bus.evt_count); else n_pass++;
        n_checks++; if (bus.err !== 1'b0 || bus.ch_rd_request !== '0) $display("FAIL reset_err_req: got %b %b required 0 0", bus.err, bus.ch_rd_request); else n_pass++;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_two_channels();
        int s; bit ok; int d0;
        clear_logs();
        base[0] = 12'h100; base[1] = 12'h7A0; base[2] = 12'h300; base[3] = 12'h5B0;
        d0 = done_cnt;
        expect_event(4'b0101, 8'd3);
        pulse_start(4'b0101, 8'd3, s);
        wait_done(300, ok);
        if (ok) exp_evt++;
        n_checks++; if (!ok) $display("FAIL two_ch_done_timeout: got no done required done"); else n_pass++;
        n_checks++; if (rq_ch.size() != 2) $display("FAIL two_ch_req_count: got %0d required 2", rq_ch.size()); else n_pass++;
        if (rq_ch.size() == 2) begin
            n_checks++; if (rq_ch[0] != 0 || rq_ch[1] != 2) $display("FAIL two_ch_req_order: got %0d,%0d required 0,2", rq_ch[0], rq_ch[1]); else n_pass++;
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL two_ch_missing_words: got %0d left required 0", exp_q.size()); else n_pass++;
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL two_ch_done_count: got %0d required 1", done_cnt - d0); else n_pass++;
        n_checks++; if (bus.evt_count !== exp_evt) $display("FAIL two_ch_evt_count: got %0d required %0d", bus.evt_count, exp_evt); else n_pass++;
        $display("two_channels: event done, evt_count %0d", bus.evt_count);
    endtask

    task automatic test_latency();
        int s; bit ok;
        clear_logs();
        base[0] = 12'd1;
        expect_event(4'b0001, 8'd3);
        pulse_start(4'b0001, 8'd3, s);
        wait_done(200, ok);
        if (ok) exp_evt++;
        n_checks++; if (!ok) $display("FAIL latency_done_timeout: got no done required done"); else n_pass++;
        n_checks++; if (rq_cyc.size() != 1 || vq_cyc.size() != 4) $display("FAIL latency_counts: got %0d req %0d words required 1 req 4 words", rq_cyc.size(), vq_cyc.size()); else n_pass++;
        if (rq_cyc.size() == 1 && vq_cyc.size() == 4) begin
            n_checks++; if (vq_cyc[0] != rq_cyc[0] + 1) $display("FAIL latency_header: got T+%0d required T+1", vq_cyc[0] - rq_cyc[0]); else n_pass++;
            n_checks++; if (vq_cyc[1] != rq_cyc[0] + READ_LAT + 1) $display("FAIL latency_word0: got T+%0d required T+%0d", vq_cyc[1] - rq_cyc[0], READ_LAT + 1); else n_pass++;
            n_checks++; if (vq_cyc[3] != rq_cyc[0] + READ_LAT + 3) $display("FAIL latency_word2: got T+%0d required T+%0d", vq_cyc[3] - rq_cyc[0], READ_LAT + 3); else n_pass++;
        end
        $display("latency: header and ramp timing checked");
    endtask

    task automatic test_fifo_space();
        int s; int r; bit ok;
        clear_logs();
        base[0] = 12'h040;
        bus.fifo_space = 9'd8;
        expect_event(4'b0001, 8'd8);
        pulse_start(4'b0001, 8'd8, s);
        repeat (20) @(negedge clk);
        n_checks++; if (rq_cyc.size() != 0 || vq_cyc.size() != 0) $display("FAIL space_held: got %0d req %0d words required 0 0", rq_cyc.size(), vq_cyc.size()); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL space_busy: got %b required 1", bus.busy); else n_pass++;
        bus.fifo_space = 9'd9;
        r = cyc;
        wait_done(200, ok);
        if (ok) exp_evt++;
        n_checks++; if (!ok) $display("FAIL space_done_timeout: got no done required done"); else n_pass++;
        if (rq_cyc.size() > 0 && vq_cyc.size() > 0) begin
            n_checks++; if (rq_cyc[0] != r + 1) $display("FAIL space_req_cycle: got R+%0d required R+1", rq_cyc[0] - r); else n_pass++;
            n_checks++; if (vq_cyc[0] != r + 2) $display("FAIL space_valid_cycle: got R+%0d required R+2", vq_cyc[0] - r); else n_pass++;
        end else begin
            n_checks++; $display("FAIL space_no_activity: got %0d req required 1", rq_cyc.size());
        end
        n_checks++; if (exp_q.size() != 0) $display("FAIL space_missing_words: got %0d left required 0", exp_q.size()); else n_pass++;
        bus.fifo_space = 9'h1FF;
        $display("fifo_space: released at cycle %0d", r);
    endtask

    task automatic test_zero_work();
        int s; bit ok; logic [7:0] e0;
        clear_logs();
        pulse_start(4'b0000, 8'd5, s);
        wait_done(20, ok);
        if (ok) exp_evt++;
        n_checks++; if (!ok || done_cyc != s + 2) $display("FAIL zero_mask_done: got S+%0d required S+2", done_cyc - s); else n_pass++;
        pulse_start(4'b1111, 8'd0, s);
        wait_done(20, ok);
        if (ok) exp_evt++;
        n_checks++; if (!ok || done_cyc != s + 2) $display("FAIL zero_howmany_done: got S+%0d required S+2", done_cyc - s); else n_pass++;
        n_checks++; if (rq_cyc.size() != 0 || vq_cyc.size() != 0) $display("FAIL zero_activity: got %0d req %0d words required 0 0", rq_cyc.size(), vq_cyc.size()); else n_pass++;
        n_checks++; if (bus.evt_count !== exp_evt) $display("FAIL zero_evt_count: got %0d required %0d", bus.evt_count, exp_evt); else n_pass++;
        e0 = exp_evt;
        for (int n = 0; n < 256; n++) begin
            pulse_start(4'b0000, 8'd1, s);
            wait_done(20, ok);
            if (ok) exp_evt++;
            if (exp_evt == 8'd0) begin
                n_checks++; if (bus.evt_count !== 8'd0) $display("FAIL evt_wrap: got %0d required 0", bus.evt_count); else n_pass++;
            end
        end
        n_checks++; if (bus.evt_count !== e0) $display("FAIL evt_256_events: got %0d required %0d", bus.evt_count, e0); else n_pass++;
        $display("zero_work: 258 empty events, evt_count %0d", bus.evt_count);
    endtask

    task automatic test_err();
        int s; bit ok; bit seen;
        clear_logs();
        base[1] = 12'h200;
        expect_event(4'b0010, 8'd4);
        pulse_start(4'b0010, 8'd4, s);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (vq_cyc.size() > 0) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (!seen) $display("FAIL err_no_header: got none required header"); else n_pass++;
        pulse_start(4'b1111, 8'd7, s);
        n_checks++; if (bus.err !== 1'b1) $display("FAIL err_set: got %b required 1", bus.err); else n_pass++;
        wait_done(200, ok);
        if (ok) exp_evt++;
        n_checks++; if (!ok || exp_q.size() != 0 || rq_ch.size() != 1) $display("FAIL err_event_intact: got done=%0d left=%0d req=%0d required 1 0 1", ok, exp_q.size(), rq_ch.size()); else n_pass++;
        n_checks++; if (bus.err !== 1'b1) $display("FAIL err_sticky: got %b required 1", bus.err); else n_pass++;
        pulse_start(4'b0000, 8'd0, s);
        n_checks++; if (bus.err !== 1'b0) $display("FAIL err_clear: got %b required 0", bus.err); else n_pass++;
        wait_done(20, ok);
        if (ok) exp_evt++;
        n_checks++; if (bus.evt_count !== exp_evt) $display("FAIL err_evt_count: got %0d required %0d", bus.evt_count, exp_evt); else n_pass++;
        $display("err: ignored start flagged and cleared");
    endtask

    task automatic test_async_reset();
        int s; bit ok; bit seen;
        clear_logs();
        for (int i = 0; i < NCH; i++) base[i] = 12'(i * 64 + 8);
        expect_event(4'b1111, 8'd8);
        pulse_start(4'b1111, 8'd8, s);
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (vq_cyc.size() >= 3) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (!seen) $display("FAIL areset_no_stream: got %0d words required 3", vq_cyc.size()); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0) $display("FAIL areset_stream: got %b %h required 0 0", bus.out_valid, bus.out_data); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0 || bus.ch_rd_request !== '0) $display("FAIL areset_busy_req: got %b %b required 0 0", bus.busy, bus.ch_rd_request); else n_pass++;
        n_checks++; if (bus.evt_count !== 8'd0 || bus.err !== 1'b0) $display("FAIL areset_count_err: got %0d %b required 0 0", bus.evt_count, bus.err); else n_pass++;
        exp_q.delete();
        exp_evt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        expect_event(4'b0010, 8'd2);
        pulse_start(4'b0010, 8'd2, s);
        wait_done(200, ok);
        if (ok) exp_evt++;
        n_checks++; if (!ok || exp_q.size() != 0 || rq_ch.size() != 1) $display("FAIL areset_fresh_event: got done=%0d left=%0d req=%0d required 1 0 1", ok, exp_q.size(), rq_ch.size()); else n_pass++;
        n_checks++; if (bus.evt_count !== 8'd1) $display("FAIL areset_fresh_count: got %0d required 1", bus.evt_count); else n_pass++;
        $display("async_reset: abandoned event, fresh event completed");
    endtask

    initial begin
        test_reset();
        test_two_channels();
        test_latency();
        test_fifo_space();
        test_zero_work();
        test_err();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
